// File: rtl/swlw_symbol_encoder_if.sv
// Commit-stage bus into the swlw symbol encoder: two commit ports per cycle, port 0 is the older one.
interface swlw_symbol_encoder_if #(
    parameter int ADDR_W = 64
) ();
    logic [1:0]          valid;
    logic [1:0]          store;
    logic [1:0]          load;
    logic [2*ADDR_W-1:0] addr;

    modport master (output valid, output store, output load, output addr);
    modport slave  (input valid, input store, input load, input addr);
endinterface

// File: rtl/swlw_symbol_encoder.sv
// Turns committed instructions into the 8-bit swlw automaton symbol stream and sequences the automaton run/reset.
// Optional build macro SWLW_ENC_FILTER_EN: discard class-00 (neither store nor load) commits before the FIFO.
module swlw_symbol_encoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int RST_CYCLES = 2,
    parameter int ADDR_W     = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable_i,
    swlw_symbol_encoder_if.slave        commit,
    output logic [7:0]                  mon_symbols_o,
    output logic                        mon_run_o,
    output logic                        mon_reset_o,
    output logic                        busy_o,
    output logic                        overflow_o,
    output logic [7:0]                  drop_cnt_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RST    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t             state_r;
    logic [RC_W-1:0]    rst_cnt_r;
    logic [7:0]         mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic [7:0]         sym0_s;
    logic [7:0]         sym1_s;
    logic               cand0_s;
    logic               cand1_s;
    logic               in_emit_s;
    logic               emit_stored_s;
    logic [CNT_W-1:0]   cap_s;
    logic               acc0_s;
    logic               acc1_s;
    logic               byp_s;
    logic [1:0]         n_acc_s;
    logic [1:0]         n_wr_s;
    logic [1:0]         n_drop_s;
    logic [7:0]         first_s;
    logic [7:0]         wr_a_s;
    logic [8:0]         drop_sum_s;
    logic               unused_addr_s;

    // Symbol layout: {port[1:0], class = {load, store}, addr[5:2]}
    function automatic logic [7:0] encode_symbol(input logic port, input logic store,
                                                 input logic load, input logic [3:0] addr_bits);
        return {1'b0, port, load, store, addr_bits};
    endfunction

    assign sym0_s = encode_symbol(1'b0, commit.store[0], commit.load[0], commit.addr[5:2]);
    assign sym1_s = encode_symbol(1'b1, commit.store[1], commit.load[1], commit.addr[ADDR_W+5:ADDR_W+2]);
    assign unused_addr_s = ^commit.addr;

`ifdef SWLW_ENC_FILTER_EN
    assign cand0_s = (state_r == ST_STREAM) & commit.valid[0] & (commit.store[0] | commit.load[0]);
    assign cand1_s = (state_r == ST_STREAM) & commit.valid[1] & (commit.store[1] | commit.load[1]);
`else
    assign cand0_s = (state_r == ST_STREAM) & commit.valid[0];
    assign cand1_s = (state_r == ST_STREAM) & commit.valid[1];
`endif

    // A stored entry leaves this cycle, so its slot is already usable by this cycle's commits.
    assign in_emit_s     = (state_r == ST_STREAM) | (state_r == ST_DRAIN);
    assign emit_stored_s = in_emit_s & (count_r != CNT_W'(0));
    assign cap_s         = CNT_W'(FIFO_DEPTH) - count_r + CNT_W'(emit_stored_s);
    assign acc0_s        = cand0_s & (cap_s >= CNT_W'(1));
    assign acc1_s        = cand1_s & (cap_s >= (acc0_s ? CNT_W'(2) : CNT_W'(1)));
    assign n_acc_s       = {1'b0, acc0_s} + {1'b0, acc1_s};
    assign n_drop_s      = {1'b0, cand0_s & ~acc0_s} + {1'b0, cand1_s & ~acc1_s};
    assign drop_sum_s    = {1'b0, drop_cnt_o} + {7'd0, n_drop_s};

    // Empty FIFO: the oldest accepted commit goes straight to the output register.
    assign byp_s   = in_emit_s & (count_r == CNT_W'(0)) & (n_acc_s != 2'd0);
    assign first_s = acc0_s ? sym0_s : sym1_s;
    assign n_wr_s  = n_acc_s - {1'b0, byp_s};
    assign wr_a_s  = byp_s ? sym1_s : first_s;

    // Symbol storage (no reset needed; occupancy is tracked by the pointers)
    always_ff @(posedge clk) begin
        if (n_wr_s != 2'd0) begin
            mem_r[wr_ptr_r] <= wr_a_s;
        end
        if (n_wr_s == 2'd2) begin
            mem_r[wr_ptr_r + PTR_W'(1)] <= sym1_s;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(n_wr_s);
            rd_ptr_r <= rd_ptr_r + PTR_W'(emit_stored_s);
            count_r  <= count_r + CNT_W'(n_wr_s) - CNT_W'(emit_stored_s);
        end
    end

    // Session FSM with registered automaton controls, symbol output and drop status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            rst_cnt_r     <= RC_W'(0);
            mon_reset_o   <= 1'b1;
            mon_run_o     <= 1'b0;
            mon_symbols_o <= 8'h00;
            busy_o        <= 1'b0;
            overflow_o    <= 1'b0;
            drop_cnt_o    <= 8'd0;
        end else begin
            if (emit_stored_s) begin
                mon_symbols_o <= mem_r[rd_ptr_r];
                mon_run_o     <= 1'b1;
            end else if (byp_s) begin
                mon_symbols_o <= first_s;
                mon_run_o     <= 1'b1;
            end else begin
                mon_run_o     <= 1'b0;
            end

            if (n_drop_s != 2'd0) begin
                overflow_o <= 1'b1;
                drop_cnt_o <= drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
            end

            case (state_r)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_r     <= ST_RST;
                        rst_cnt_r   <= RC_LOAD;
                        mon_reset_o <= 1'b1;
                        busy_o      <= 1'b1;
                        overflow_o  <= 1'b0;
                        drop_cnt_o  <= 8'd0;
                    end else begin
                        mon_reset_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end
                end
                ST_RST: begin
                    busy_o <= 1'b1;
                    if (rst_cnt_r == RC_W'(0)) begin
                        state_r     <= ST_STREAM;
                        mon_reset_o <= 1'b0;
                    end else begin
                        rst_cnt_r   <= rst_cnt_r - RC_W'(1);
                        mon_reset_o <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    mon_reset_o <= 1'b0;
                    busy_o      <= 1'b1;
                    if (!enable_i) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leave only once the last symbol has been shown, so run and reset never overlap.
                    if (enable_i) begin
                        state_r     <= ST_STREAM;
                        mon_reset_o <= 1'b0;
                        busy_o      <= 1'b1;
                    end else if (count_r == CNT_W'(0)) begin
                        state_r     <= ST_IDLE;
                        mon_reset_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end else begin
                        mon_reset_o <= 1'b0;
                        busy_o      <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    mon_reset_o <= 1'b1;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end
endmodule
